// File: rtl/gpio_cfg_if.sv
// gpio_cfg_if: serial configuration bus of one gpio_cfg_loader instance.
// The master drives frame data and strobes; the slave (loader) returns chain data and status.
interface gpio_cfg_if;
    logic serial_in;
    logic shift_en;
    logic load;
    logic serial_out;
    logic cfg_busy;
    logic cfg_err;

    modport master (
        output serial_in, shift_en, load,
        input  serial_out, cfg_busy, cfg_err
    );

    modport slave (
        input  serial_in, shift_en, load,
        output serial_out, cfg_busy, cfg_err
    );
endinterface

// File: rtl/gpio_cfg_loader.sv
// gpio_cfg_loader: per-pad serial configuration loader with atomic commit on load.
// Define GPIO_CFG_PARITY_EN to append an odd-parity bit to every frame and check it at commit.
module gpio_cfg_loader #(
    parameter int unsigned         CFG_BITS  = 4,
    parameter logic [CFG_BITS-1:0] RESET_CFG = 4'b0010
) (
    input  logic      clk,
    input  logic      reset,
    gpio_cfg_if.slave cfg,
    input  logic      mgmt_out,
    input  logic      user_out,
    output logic      gpio_out,
    output logic      gpio_outenb,
    output logic      gpio_pu,
    output logic      gpio_pd
);

`ifdef GPIO_CFG_PARITY_EN
    localparam int unsigned FRAME_BITS = CFG_BITS + 1;
`else
    localparam int unsigned FRAME_BITS = CFG_BITS;
`endif
    localparam int unsigned     CNT_W    = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL, APPLY} state_t;

    state_t                state, state_nxt;
    logic [FRAME_BITS-1:0] shadow, shadow_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [CFG_BITS-1:0]   cfg_q;
    logic                  err_q;
    logic                  serial_out_q;
    logic                  load_taken;
    logic                  frame_ok;

    // The shift is resolved first so a load in the same cycle judges the post-shift frame.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        shadow_nxt = shadow;
        cnt_nxt    = cnt;
        if (cfg.shift_en) begin
            shadow_nxt = {cfg.serial_in, shadow[FRAME_BITS-1:1]};
            if (cnt != CNT_FULL)
                cnt_nxt = cnt + 1'b1;
        end
    end

    always_comb begin
        frame_ok = (cnt_nxt == CNT_FULL) && !(shadow_nxt[2] && shadow_nxt[3]);
`ifdef GPIO_CFG_PARITY_EN
        frame_ok = frame_ok && (^shadow_nxt);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_taken = 1'b0;
        case (state)
            APPLY: state_nxt = IDLE;
            default: begin
                if (cfg.load) begin
                    state_nxt  = APPLY;
                    load_taken = 1'b1;
                end else if (cfg.shift_en) begin
                    state_nxt = (cnt_nxt == CNT_FULL) ? FULL : SHIFT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow       <= '0;
            cnt          <= '0;
            cfg_q        <= RESET_CFG;
            err_q        <= 1'b0;
            serial_out_q <= 1'b0;
            gpio_out     <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            cnt    <= (state == APPLY) ? '0 : cnt_nxt;
            if (cfg.shift_en)
                serial_out_q <= shadow[0];
            if (load_taken) begin
                if (frame_ok)
                    cfg_q <= shadow_nxt[CFG_BITS-1:0];
                err_q <= !frame_ok;
            end
            gpio_out <= cfg_q[0] ? mgmt_out : user_out;
        end
    end

    assign gpio_outenb    = cfg_q[1];
    assign gpio_pu        = cfg_q[2];
    assign gpio_pd        = cfg_q[3];
    assign cfg.serial_out = serial_out_q;
    assign cfg.cfg_busy   = (state == SHIFT);
    assign cfg.cfg_err    = err_q;

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// tb_gpio_cfg_loader: two daisy-chained loaders checked every cycle against a frame-level model.
// Directed scenarios first, then a randomized stretch of shift/load/reset traffic.
module tb_gpio_cfg_loader;

    logic clk = 1'b0;
    logic reset;
    logic mgmt_out, user_out;
    logic gout_a, oeb_a, pu_a, pd_a;
    logic gout_b, oeb_b, pu_b, pd_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gpio_cfg_if cfg_a ();
    gpio_cfg_if cfg_b ();

    // Second instance sits downstream of the first and shares the strobes.
    assign cfg_b.serial_in = cfg_a.serial_out;
    assign cfg_b.shift_en  = cfg_a.shift_en;
    assign cfg_b.load      = cfg_a.load;

    gpio_cfg_loader dut_a (
        .clk(clk), .reset(reset), .cfg(cfg_a),
        .mgmt_out(mgmt_out), .user_out(user_out),
        .gpio_out(gout_a), .gpio_outenb(oeb_a), .gpio_pu(pu_a), .gpio_pd(pd_a)
    );

    gpio_cfg_loader dut_b (
        .clk(clk), .reset(reset), .cfg(cfg_b),
        .mgmt_out(mgmt_out), .user_out(user_out),
        .gpio_out(gout_b), .gpio_outenb(oeb_b), .gpio_pu(pu_b), .gpio_pd(pd_b)
    );

    // Reference model: each shadow is a 4-deep FIFO of the most recent bits (index 0 oldest).
    bit         qa[$];
    bit         qb[$];
    int         m_cnt[2];
    logic [3:0] m_cfg[2];
    bit         m_err[2];
    bit         m_so[2];
    bit         m_gout[2];
    bit         m_apply;

    function automatic logic [3:0] frame_of(input int i);
        logic [3:0] f;
        for (int k = 0; k < 4; k++)
            f[k] = (i == 0) ? qa[k] : qb[k];
        return f;
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        for (int k = 0; k < 4; k++) begin
            qa.push_back(1'b0);
            qb.push_back(1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_cfg[i]  = 4'b0010;
            m_err[i]  = 1'b0;
            m_so[i]   = 1'b0;
            m_gout[i] = 1'b0;
        end
        m_apply = 1'b0;
    endtask

    task automatic model_step(input bit rst, input bit si, input bit sh, input bit ld,
                              input bit mo, input bit uo);
        bit         in_b;
        bit         was_apply;
        logic [3:0] f;
        if (rst) begin
            model_reset();
            return;
        end
        in_b      = m_so[0];
        was_apply = m_apply;
        for (int i = 0; i < 2; i++)
            m_gout[i] = m_cfg[i][0] ? mo : uo;
        if (sh) begin
            qa.push_back(si);
            m_so[0] = qa.pop_front();
            qb.push_back(in_b);
            m_so[1] = qb.pop_front();
        end
        for (int i = 0; i < 2; i++) begin
            if (was_apply)
                m_cnt[i] = 0;
            else if (sh && m_cnt[i] < 4)
                m_cnt[i] = m_cnt[i] + 1;
            if (!was_apply && ld) begin
                f = frame_of(i);
                if (m_cnt[i] == 4 && !(f[2] && f[3])) begin
                    m_cfg[i] = f;
                    m_err[i] = 1'b0;
                end else begin
                    m_err[i] = 1'b1;
                end
            end
        end
        m_apply = !was_apply && ld;
    endtask

    function automatic bit model_busy(input int i);
        return !m_apply && m_cnt[i] > 0 && m_cnt[i] < 4;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("a_gpio_out",    gout_a,           m_gout[0]);
        check("a_outenb",      oeb_a,            m_cfg[0][1]);
        check("a_pu",          pu_a,             m_cfg[0][2]);
        check("a_pd",          pd_a,             m_cfg[0][3]);
        check("a_busy",        cfg_a.cfg_busy,   model_busy(0));
        check("a_err",         cfg_a.cfg_err,    m_err[0]);
        check("a_serial_out",  cfg_a.serial_out, m_so[0]);
        check("b_gpio_out",    gout_b,           m_gout[1]);
        check("b_outenb",      oeb_b,            m_cfg[1][1]);
        check("b_pu",          pu_b,             m_cfg[1][2]);
        check("b_pd",          pd_b,             m_cfg[1][3]);
        check("b_err",         cfg_b.cfg_err,    m_err[1]);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare 1 ns later.
    task automatic step(input bit rst, input bit si, input bit sh, input bit ld,
                        input bit mo, input bit uo);
        reset          = rst;
        cfg_a.serial_in = si;
        cfg_a.shift_en = sh;
        cfg_a.load     = ld;
        mgmt_out       = mo;
        user_out       = uo;
        @(posedge clk);
        model_step(rst, si, sh, ld, mo, uo);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] fr;
        logic [7:0] d;
        bit         sh_block;
        bit         r, sh, ld;

        model_reset();

        // Reset held for two cycles.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_outenb", oeb_a, 1'b1);
        check("rst_pu",     pu_a, 1'b0);
        check("rst_pd",     pd_a, 1'b0);
        check("rst_gout",   gout_a, 1'b0);
        check("rst_err",    cfg_a.cfg_err, 1'b0);

        // Good frame 0101: mgmt-owned, output enabled, pull-up.
        fr = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step(0, fr[k], 1, 0, 1, 0);
            if (k == 1) check("busy_mid", cfg_a.cfg_busy, 1'b1);
        end
        check("full_not_busy", cfg_a.cfg_busy, 1'b0);
        step(0, 0, 0, 1, 1, 0);
        check("good_outenb", oeb_a, 1'b0);
        check("good_pu",     pu_a, 1'b1);
        check("good_err",    cfg_a.cfg_err, 1'b0);
        check("gout_commit_edge", gout_a, 1'b0);
        step(0, 0, 0, 0, 1, 0);
        check("gout_mgmt", gout_a, 1'b1);

        // Short frame: no commit, error set; then a good frame clears it.
        fr = 4'b1010;
        for (int k = 0; k < 3; k++) step(0, fr[k], 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        check("short_pu_kept", pu_a, 1'b1);
        check("short_err",     cfg_a.cfg_err, 1'b1);
        step(0, 0, 0, 0, 0, 1);
        fr = 4'b0011;
        for (int k = 0; k < 4; k++) step(0, fr[k], 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        check("recover_err",    cfg_a.cfg_err, 1'b0);
        check("recover_outenb", oeb_a, 1'b1);
        step(0, 0, 0, 0, 0, 1);

        // Both pulls requested: rejected.
        fr = 4'b1100;
        for (int k = 0; k < 4; k++) step(0, fr[k], 1, 0, 1, 1);
        step(0, 0, 0, 1, 1, 1);
        check("pulls_err", cfg_a.cfg_err, 1'b1);
        check("pulls_pd",  pd_a, 1'b0);
        step(0, 0, 0, 0, 1, 1);

        // Load together with the fourth shift, then a load inside APPLY.
        fr = 4'b0110;
        for (int k = 0; k < 3; k++) step(0, fr[k], 1, 0, 0, 0);
        step(0, fr[3], 1, 1, 0, 0);
        check("simul_outenb", oeb_a, 1'b1);
        check("simul_pu",     pu_a, 1'b1);
        check("simul_err",    cfg_a.cfg_err, 1'b0);
        step(0, 0, 0, 1, 0, 0);
        check("apply_load_ignored", cfg_a.cfg_err, 1'b0);
        step(0, 0, 0, 0, 0, 0);

        // Reset during the second shift.
        step(0, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        check("midrst_outenb", oeb_a, 1'b1);
        check("midrst_pu",     pu_a, 1'b0);
        check("midrst_busy",   cfg_a.cfg_busy, 1'b0);

        // Daisy chain: eight shifts in one load window.
        d = 8'b0101_0010;
        for (int k = 0; k < 8; k++) begin
            step(0, d[k], 1, 0, 0, 0);
            if (k >= 4) check("chain_lag", cfg_a.serial_out, d[k-4]);
        end
        step(0, 0, 0, 1, 0, 0);
        check("chain_a_cfg", {pd_a, pu_a, oeb_a}, d[7:5]);
        check("chain_b_pu",  pu_b, d[1]);
        check("chain_b_pd",  pd_b, d[2]);
        check("chain_b_oeb", oeb_b, d[0]);
        step(0, 0, 0, 0, 0, 0);

        // Randomized traffic; no shift is issued in the cycle following a load.
        sh_block = 1'b0;
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            sh = !sh_block && ($urandom_range(0, 9) < 6);
            ld = ($urandom_range(0, 9) == 0);
            step(r, 1'($urandom_range(0, 1)), sh, ld,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            sh_block = ld && !r;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
